// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, op encoding.
// Used by the ALU, the arbiter and the instruction decoder.
package alu_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_OR   = 4'b0111,
    ALU_AND  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32 integer ALU.
// Unknown op codes produce zero.
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]     i_a,
  input  logic [XLEN-1:0]     i_b,
  input  logic [ALU_OP_W-1:0] i_op,
  output logic [XLEN-1:0]     o_y
);

  logic [4:0] w_shamt;

  assign w_shamt = i_b[4:0];

  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_SLL:  o_y = i_a << w_shamt;
      ALU_SLT:  o_y = {{(XLEN-1){1'b0}},
                       $signed(i_a) < $signed(i_b)};
      ALU_SLTU: o_y = {{(XLEN-1){1'b0}}, i_a < i_b};
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SRL:  o_y = i_a >> w_shamt;
      ALU_OR:   o_y = i_a | i_b;
      ALU_AND:  o_y = i_a & i_b;
      ALU_SRA:  o_y = $unsigned($signed(i_a) >>> w_shamt);
      default:  o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters,
// with a single-entry tagged result register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*XLEN-1:0]      i_req_operand_a,
  input  logic [NUM_REQ*XLEN-1:0]      i_req_operand_b,
  input  logic [NUM_REQ*ALU_OP_W-1:0]  i_req_alu_op,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic                         o_rsp_valid,
  output logic [XLEN-1:0]              o_rsp_data,
  output logic [ID_W-1:0]              o_rsp_id,
  input  logic                         i_rsp_ready
);

  logic [ID_W-1:0]     r_rr_ptr;
  logic                r_rsp_valid;
  logic [XLEN-1:0]     r_rsp_data;
  logic [ID_W-1:0]     r_rsp_id;

  logic                w_gnt_vld;
  logic [ID_W-1:0]     w_gnt;
  logic                w_slot_free;
  logic                w_accept;
  logic [XLEN-1:0]     w_a;
  logic [XLEN-1:0]     w_b;
  logic [ALU_OP_W-1:0] w_op;
  logic [XLEN-1:0]     w_y;

  // Walk the search order backwards so the last hit is the highest priority.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = ID_W'((int'(r_rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign w_slot_free = !r_rsp_valid || i_rsp_ready;
  assign w_accept    = w_gnt_vld && w_slot_free && !i_rst;

  always_comb begin
    o_req_ready = '0;
    if (w_accept) o_req_ready[w_gnt] = 1'b1;
  end

  // With no grant w_gnt is zero, so requester 0 feeds the ALU harmlessly.
  assign w_a  = i_req_operand_a[XLEN*int'(w_gnt) +: XLEN];
  assign w_b  = i_req_operand_b[XLEN*int'(w_gnt) +: XLEN];
  assign w_op = i_req_alu_op[ALU_OP_W*int'(w_gnt) +: ALU_OP_W];

  alu u_alu (
    .i_a  (w_a),
    .i_b  (w_b),
    .i_op (w_op),
    .o_y  (w_y)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_y;
      r_rsp_id    <= w_gnt;
      r_rr_ptr    <= ID_W'((int'(w_gnt) + 1) % NUM_REQ);
    end else if (i_rsp_ready && r_rsp_valid) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_id    = r_rsp_id;

endmodule
